byte_deserializer: RTL
======================

# byte_deserializer

Serial-to-parallel front end that assembles an 8-bit byte from a 1-bit input stream and presents it on a valid/ready output. It sits directly upstream of the byte-wide AND reduction stage, which consumes `byte_out` to flag all-ones bytes. The block holds one completed byte while the next one is shifted in, and raises a sticky overflow flag when a completed byte cannot be delivered.

## Interface
- `MSB_FIRST`, default 1: 1 = the first received bit lands in `byte_out[7]`; 0 = the first received bit lands in `byte_out[0]`.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is accepted this cycle. There is no upstream backpressure: every valid bit is taken.
- `frame_start`  in  1  resync: discard any partial byte. If `bit_valid` is also high, `bit_in` becomes bit 0 of a new byte.
- `byte_out`  out  8  assembled byte, registered.
- `byte_valid`  out  1  `byte_out` holds an undelivered byte.
- `byte_ready`  in  1  downstream accepts `byte_out` this cycle when `byte_valid=1`.
- `ovf_clr`  in  1  clears `overflow`.
- `overflow`  out  1  sticky flag: a completed byte was dropped.
- `bit_cnt`  out  3  number of bits of the partial byte held, 0..7.

## Operation
- Shift register `sr[7:0]` plus 3-bit counter `bit_cnt`.
  - `MSB_FIRST=1`: `sr <= {sr[6:0], bit_in}`.
  - `MSB_FIRST=0`: `sr <= {bit_in, sr[7:1]}`.
- Accepted bit (`bit_valid=1`):
  - With `bit_cnt<7`: shift, then `bit_cnt++`.
  - With `bit_cnt==7`: this is the 8th bit. The full byte (`sr` shifted with `bit_in`) is completed, and `bit_cnt` wraps to 0.
- `frame_start=1`:
  - `bit_cnt` is forced to 0, and the partial byte is discarded.
  - If `bit_valid=1` in the same cycle, the bit is shifted in and `bit_cnt=1`. A completion cannot occur in that cycle.
- Output holding register, two states:
  - EMPTY (`byte_valid=0`): a completion loads `byte_out` and moves the register to FULL.
  - FULL (`byte_valid=1`):
    - `byte_ready=1` and no completion: go to EMPTY.
    - `byte_ready=1` and a completion in the same cycle: load the new byte and stay FULL. This gives back-to-back throughput with no dropped byte.
    - `byte_ready=0` and a completion: the new byte is dropped, `byte_out` is unchanged, and `overflow<=1`.
    - `byte_ready=0` and no completion: hold.
- `byte_ready` while EMPTY: ignored.
- `overflow`:
  - Set and `ovf_clr` in the same cycle: set wins (stays 1).
  - `ovf_clr` alone: `overflow<=0`.
- `byte_out` stays stable while `byte_valid=1` and `byte_ready=0`.

## Timing
- Reset values: `byte_out=8'h00`, `byte_valid=0`, `overflow=0`, `bit_cnt=0`, `sr=0`.
- Reset mid-byte discards the partial byte and the held byte. The stream restarts with bit 0 on the first valid bit after `rst` deasserts.
- Latency: the 8th bit is accepted at edge N. `byte_out` and `byte_valid` are updated at edge N, visible in cycle N+1.
- Handshake: transfer occurs on an edge where `byte_valid=1` and `byte_ready=1`. `byte_valid` falls on that same edge unless a completion reloads the register.
- `bit_valid` gaps of any length are allowed. `bit_cnt` and `sr` hold during gaps.
- `overflow` rises on the edge of the dropped completion.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- MSB_FIRST=1: send bits 1,0,1,1,0,0,1,0 on consecutive cycles with `byte_ready=1` -> `byte_out=8'hB2`, `byte_valid` high for exactly 1 cycle, starting 1 cycle after the 8th bit; `bit_cnt` sequence 1..7, 0.
- MSB_FIRST=0: the same bits -> `byte_out=8'h4D`. Also insert random 1–5 cycle `bit_valid` gaps -> identical result.
- Backpressure: `byte_ready=0`, send 8×1 then 8×0 -> `byte_out` holds `8'hFF`, `byte_valid=1`, `overflow=1` after the 16th bit. Raise `byte_ready` -> `byte_valid=0` next cycle. Pulse `ovf_clr` -> `overflow=0`.
- Coincident accept and complete: hold `byte_ready=1` and stream `8'hFF`, `8'h00`, `8'hA5` continuously -> three bytes delivered in order, 8 cycles apart, `overflow=0`.
- Resync: send 1,1,1, then assert `frame_start` with `bit_valid` and bit 0, followed by 0,0,0,0,0,0,1 -> `byte_out=8'h01` (MSB_FIRST=1), and the 3 stale bits are discarded.
- Reset: assert `rst` after 5 bits with a byte held -> all outputs at reset values next cycle. The next 8 bits produce a correct fresh byte.

Source files
------------

// File: rtl/byte_deserializer.sv
// ============================================================================
// Module   : byte_deserializer
// Purpose  : 1-bit serial to 8-bit parallel converter with a single-entry
//            valid/ready output register and a sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_deserializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       frame_start,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    input  logic       ovf_clr,
    output logic       overflow,
    output logic [2:0] bit_cnt
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] out_q, out_d;
    logic       ovf_q, ovf_d;

    logic [7:0] w_base;
    logic [7:0] w_shifted;
    logic       w_complete;
    logic       w_ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            sr_q    <= 8'h00;
            cnt_q   <= 3'd0;
            out_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    // A resync starts the new byte from a clean shift register.
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        w_complete = 1'b0;
        w_base     = frame_start ? 8'h00 : sr_q;
        w_shifted  = MSB_FIRST ? {w_base[6:0], bit_in} : {bit_in, w_base[7:1]};
        if (bit_valid) begin
            sr_d = w_shifted;
            if (frame_start) begin
                cnt_d = 3'd1;
            end else begin
                cnt_d      = cnt_q + 3'd1;
                w_complete = (cnt_q == 3'd7);
            end
        end else if (frame_start) begin
            sr_d  = 8'h00;
            cnt_d = 3'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        w_ovf_set = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (w_complete) begin
                    out_d   = w_shifted;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (byte_ready) begin
                    if (w_complete) begin
                        out_d = w_shifted;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end else if (w_complete) begin
                    w_ovf_set = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        ovf_d = w_ovf_set | (ovf_q & ~ovf_clr);
    end

    assign byte_out   = out_q;
    assign byte_valid = (state_q == S_FULL);
    assign overflow   = ovf_q;
    assign bit_cnt    = cnt_q;

endmodule

`default_nettype wire
